// File: rtl/lcl_mem_responder.sv
// ---------------------------------------------------------------------------
// lcl_mem_responder
//   Memory-side responder for the lcl_* burst write/read channels. Write
//   bursts land in, and read bursts are served from, an internal dual-port
//   RAM (one write port, one read port, read-first on a same-word collision).
//   Serves as on-chip scratch memory and as a simulation target for lcl_*
//   initiators.
//
// Parameters
//   ADDR_WIDTH      byte address width of lcl_iaddr / lcl_oaddr
//   DATA_WIDTH      beat width (power of 2, >= 8); B = DATA_WIDTH/8 bytes
//   MEM_DEPTH_LOG2  log2 of RAM depth in beats
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   lcl_istart/iaddr/inum           write burst request, start address, beats
//   lcl_ibusy, lcl_irdy             write channel occupied / accepting beats
//   lcl_den, lcl_din, lcl_idone     write beat valid, data, burst end
//   lcl_ostart/oaddr/onum           read burst request, start address, beats
//   lcl_obusy, lcl_ordy             read channel occupied / accepting rden
//   lcl_rden                        read beat request
//   lcl_dv, lcl_dout, lcl_odone     read data valid, data, burst complete
//   err_flags                       sticky protocol errors
//                                   [0] den_nrdy [1] rden_nrdy [2] start_busy
//
// Configuration
//   LCL_RESP_ERRCHK_EN  when defined, the sticky protocol checker drives
//                       err_flags; otherwise err_flags is tied to zero.
// ---------------------------------------------------------------------------
module lcl_mem_responder #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write channel
  input  logic                  lcl_istart,
  input  logic [ADDR_WIDTH-1:0] lcl_iaddr,
  input  logic [7:0]            lcl_inum,
  output logic                  lcl_ibusy,
  output logic                  lcl_irdy,
  input  logic                  lcl_den,
  input  logic [DATA_WIDTH-1:0] lcl_din,
  input  logic                  lcl_idone,
  // read channel
  input  logic                  lcl_ostart,
  input  logic [ADDR_WIDTH-1:0] lcl_oaddr,
  input  logic [7:0]            lcl_onum,
  output logic                  lcl_obusy,
  output logic                  lcl_ordy,
  input  logic                  lcl_rden,
  output logic                  lcl_dv,
  output logic [DATA_WIDTH-1:0] lcl_dout,
  output logic                  lcl_odone,
  // protocol checker
  output logic [2:0]            err_flags
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BEAT_BYTES);
  localparam int DEPTH      = 1 << MEM_DEPTH_LOG2;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  // A beat count of 0 encodes a full 256-beat burst.
  function automatic logic [8:0] burst_len(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

  // Only the word-index slice of each address is meaningful; byte-lane and
  // upper bits are intentionally dropped (the RAM wraps silently).
  logic addr_unused;
  assign addr_unused = ^{lcl_iaddr, lcl_oaddr};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT} w_state_t;

  w_state_t   w_state_reg;
  idx_t       w_base_reg;
  logic [8:0] w_num_reg;
  logic [8:0] w_cnt_reg;
  logic       ibusy_reg;
  logic       irdy_reg;
  logic       w_beat;
  logic [8:0] w_cnt_next;
  idx_t       w_idx;

  assign w_beat     = lcl_den & irdy_reg;
  assign w_cnt_next = w_cnt_reg + 9'd1;
  assign w_idx      = w_base_reg + idx_t'(w_cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      w_base_reg  <= '0;
      w_num_reg   <= '0;
      w_cnt_reg   <= '0;
      ibusy_reg   <= 1'b0;
      irdy_reg    <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (lcl_istart) begin
            w_base_reg  <= lcl_iaddr[BYTE_SHIFT +: MEM_DEPTH_LOG2];
            w_num_reg   <= burst_len(lcl_inum);
            w_cnt_reg   <= '0;
            w_state_reg <= W_DATA;
            ibusy_reg   <= 1'b1;
            irdy_reg    <= 1'b1;   // every burst has at least one beat
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_cnt_reg <= w_cnt_next;
          end
          if (lcl_idone) begin
            // Early end: beats already written stay, the rest are dropped.
            w_state_reg <= W_IDLE;
            ibusy_reg   <= 1'b0;
            irdy_reg    <= 1'b0;
          end else if (w_beat && (w_cnt_next == w_num_reg)) begin
            w_state_reg <= W_WAIT;
            irdy_reg    <= 1'b0;
          end
        end
        W_WAIT: begin
          if (lcl_idone) begin
            w_state_reg <= W_IDLE;
            ibusy_reg   <= 1'b0;
          end
        end
        default: begin
          w_state_reg <= W_IDLE;
          ibusy_reg   <= 1'b0;
          irdy_reg    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      mem[w_idx] <= lcl_din;
    end
  end

  assign lcl_ibusy = ibusy_reg;
  assign lcl_irdy  = irdy_reg;

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_DRAIN} r_state_t;

  r_state_t              r_state_reg;
  idx_t                  r_base_reg;
  logic [8:0]            r_num_reg;
  logic [8:0]            r_cnt_reg;
  logic                  obusy_reg;
  logic                  ordy_reg;
  logic                  dv_reg;
  logic                  odone_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  r_beat;
  logic [8:0]            r_cnt_next;
  idx_t                  r_idx;

  assign r_beat     = lcl_rden & ordy_reg;
  assign r_cnt_next = r_cnt_reg + 9'd1;
  assign r_idx      = r_base_reg + idx_t'(r_cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      r_base_reg  <= '0;
      r_num_reg   <= '0;
      r_cnt_reg   <= '0;
      obusy_reg   <= 1'b0;
      ordy_reg    <= 1'b0;
      dv_reg      <= 1'b0;
      odone_reg   <= 1'b0;
    end else begin
      // dv/odone follow an accepted rden by exactly one cycle.
      dv_reg    <= r_beat;
      odone_reg <= r_beat && (r_cnt_next == r_num_reg);
      case (r_state_reg)
        R_IDLE: begin
          if (lcl_ostart) begin
            r_base_reg  <= lcl_oaddr[BYTE_SHIFT +: MEM_DEPTH_LOG2];
            r_num_reg   <= burst_len(lcl_onum);
            r_cnt_reg   <= '0;
            r_state_reg <= R_DATA;
            obusy_reg   <= 1'b1;
            ordy_reg    <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_beat) begin
            r_cnt_reg <= r_cnt_next;
            if (r_cnt_next == r_num_reg) begin
              r_state_reg <= R_DRAIN;
              ordy_reg    <= 1'b0;
            end
          end
        end
        R_DRAIN: begin
          // This is the cycle carrying the final dv/odone.
          r_state_reg <= R_IDLE;
          obusy_reg   <= 1'b0;
        end
        default: begin
          r_state_reg <= R_IDLE;
          obusy_reg   <= 1'b0;
          ordy_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Registered RAM read; dout only updates on an accepted beat so it holds
  // its last value whenever dv is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (r_beat) begin
      dout_reg <= mem[r_idx];
    end
  end

  assign lcl_obusy = obusy_reg;
  assign lcl_ordy  = ordy_reg;
  assign lcl_dv    = dv_reg;
  assign lcl_dout  = dout_reg;
  assign lcl_odone = odone_reg;

  // -------------------------------------------------------------------------
  // Protocol checker
  // -------------------------------------------------------------------------
`ifdef LCL_RESP_ERRCHK_EN
  logic       irdy_prev_reg;
  logic       ordy_prev_reg;
  logic [2:0] err_reg;

  // The *_prev registers forgive the single beat that an initiator with a
  // one-cycle registered enable issues right after ready falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irdy_prev_reg <= 1'b0;
      ordy_prev_reg <= 1'b0;
      err_reg       <= 3'b000;
    end else begin
      irdy_prev_reg <= irdy_reg;
      ordy_prev_reg <= ordy_reg;
      if (lcl_den && !irdy_reg && !irdy_prev_reg) begin
        err_reg[0] <= 1'b1;
      end
      if (lcl_rden && !ordy_reg && !ordy_prev_reg) begin
        err_reg[1] <= 1'b1;
      end
      if ((lcl_istart && ibusy_reg) || (lcl_ostart && obusy_reg)) begin
        err_reg[2] <= 1'b1;
      end
    end
  end

  assign err_flags = err_reg;
`else
  assign err_flags = 3'b000;
`endif

endmodule

// File: tb/tb_lcl_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lcl_mem_responder
//   Directed self-checking bench for lcl_mem_responder. A word-indexed
//   reference array holds every value written so far; read bursts are
//   compared against it beat by beat.
// ---------------------------------------------------------------------------
module tb_lcl_mem_responder;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

`ifdef LCL_RESP_ERRCHK_EN
  localparam logic [2:0] ERR_EXP = 3'b101;
`else
  localparam logic [2:0] ERR_EXP = 3'b000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lcl_istart = 1'b0;
  logic [AW-1:0] lcl_iaddr = '0;
  logic [7:0]    lcl_inum = '0;
  logic          lcl_ibusy;
  logic          lcl_irdy;
  logic          lcl_den = 1'b0;
  logic [DW-1:0] lcl_din = '0;
  logic          lcl_idone = 1'b0;
  logic          lcl_ostart = 1'b0;
  logic [AW-1:0] lcl_oaddr = '0;
  logic [7:0]    lcl_onum = '0;
  logic          lcl_obusy;
  logic          lcl_ordy;
  logic          lcl_rden = 1'b0;
  logic          lcl_dv;
  logic [DW-1:0] lcl_dout;
  logic          lcl_odone;
  logic [2:0]    err_flags;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];

  lcl_mem_responder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_DEPTH_LOG2(DL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lcl_istart(lcl_istart),
    .lcl_iaddr (lcl_iaddr),
    .lcl_inum  (lcl_inum),
    .lcl_ibusy (lcl_ibusy),
    .lcl_irdy  (lcl_irdy),
    .lcl_den   (lcl_den),
    .lcl_din   (lcl_din),
    .lcl_idone (lcl_idone),
    .lcl_ostart(lcl_ostart),
    .lcl_oaddr (lcl_oaddr),
    .lcl_onum  (lcl_onum),
    .lcl_obusy (lcl_obusy),
    .lcl_ordy  (lcl_ordy),
    .lcl_rden  (lcl_rden),
    .lcl_dv    (lcl_dv),
    .lcl_dout  (lcl_dout),
    .lcl_odone (lcl_odone),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_idx(input logic [AW-1:0] addr);
    return int'((addr >> 3) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] pattern(input logic [31:0] seed, input int i);
    return {seed, 32'(i)};
  endfunction

  // Full write burst with idone after the last beat.
  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] num,
                          input logic [31:0] seed);
    int n;
    int base;
    n    = (num == 8'd0) ? 256 : int'(num);
    base = word_idx(addr);
    lcl_istart = 1'b1; lcl_iaddr = addr; lcl_inum = num;
    cyc();
    lcl_istart = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b1) begin
      errors++; $display("FAIL wr_busy: got %0b expected 1", lcl_ibusy);
    end
    lcl_den = 1'b1;
    for (int i = 0; i < n; i++) begin
      lcl_din = pattern(seed, i);
      checks++;
      if (lcl_irdy !== 1'b1) begin
        errors++; $display("FAIL wr_irdy beat %0d: got %0b expected 1", i, lcl_irdy);
      end
      cyc();
      model[(base + i) % DEPTH] = pattern(seed, i);
    end
    lcl_den = 1'b0;
    checks++;
    if (lcl_irdy !== 1'b0 || lcl_ibusy !== 1'b1) begin
      errors++; $display("FAIL wr_wait: got irdy=%0b ibusy=%0b expected irdy=0 ibusy=1", lcl_irdy, lcl_ibusy);
    end
    lcl_idone = 1'b1;
    cyc();
    lcl_idone = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b0) begin
      errors++; $display("FAIL wr_end: got ibusy=%0b expected 0", lcl_ibusy);
    end
    $display("write burst addr=%0h beats=%0d seed=%0h", addr, n, seed);
  endtask

  // Read burst with rden held one trailing cycle after ordy falls.
  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] num);
    int n;
    int base;
    logic [DW-1:0] exp_data;
    n    = (num == 8'd0) ? 256 : int'(num);
    base = word_idx(addr);
    exp_data = '0;
    lcl_ostart = 1'b1; lcl_oaddr = addr; lcl_onum = num;
    cyc();
    lcl_ostart = 1'b0;
    checks++;
    if (lcl_obusy !== 1'b1) begin
      errors++; $display("FAIL rd_busy: got %0b expected 1", lcl_obusy);
    end
    lcl_rden = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (lcl_ordy !== 1'b1) begin
        errors++; $display("FAIL rd_ordy beat %0d: got %0b expected 1", i, lcl_ordy);
      end
      cyc();
      exp_data = model[(base + i) % DEPTH];
      checks++;
      if (lcl_dv !== 1'b1 || lcl_dout !== exp_data || lcl_odone !== (i == n - 1)) begin
        errors++;
        $display("FAIL rd_beat %0d: got dv=%0b dout=%0h odone=%0b expected dv=1 dout=%0h odone=%0b",
                 i, lcl_dv, lcl_dout, lcl_odone, exp_data, (i == n - 1));
      end
    end
    checks++;
    if (lcl_ordy !== 1'b0 || lcl_obusy !== 1'b1) begin
      errors++; $display("FAIL rd_drain: got ordy=%0b obusy=%0b expected ordy=0 obusy=1", lcl_ordy, lcl_obusy);
    end
    cyc();
    lcl_rden = 1'b0;
    checks++;
    if (lcl_dv !== 1'b0 || lcl_odone !== 1'b0 || lcl_obusy !== 1'b0 || lcl_dout !== exp_data) begin
      errors++;
      $display("FAIL rd_end: got dv=%0b odone=%0b obusy=%0b dout=%0h expected 0/0/0 dout=%0h",
               lcl_dv, lcl_odone, lcl_obusy, lcl_dout, exp_data);
    end
    $display("read burst addr=%0h beats=%0d", addr, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({lcl_ibusy, lcl_irdy, lcl_obusy, lcl_ordy, lcl_dv, lcl_odone} !== 6'b0 ||
        lcl_dout !== '0 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got ibusy=%0b irdy=%0b obusy=%0b ordy=%0b dv=%0b odone=%0b dout=%0h err=%0b expected all 0",
               lcl_ibusy, lcl_irdy, lcl_obusy, lcl_ordy, lcl_dv, lcl_odone, lcl_dout, err_flags);
    end
    rst_n = 1'b1;
    cyc();
    $display("reset released");
  endtask

  task automatic test_full_burst();
    do_write(64'h0, 8'd0, 32'h0000_F011);
    do_read(64'h0, 8'd0);
  endtask

  task automatic test_basic();
    do_write(64'h100, 8'd4, 32'hD000_0004);
    do_read(64'h100, 8'd4);
    // Low byte-lane bits and bits above the RAM index are ignored.
    do_read(64'hF000_0000_0000_0107, 8'd4);
  endtask

  task automatic test_wrap();
    do_write(64'((DEPTH - 2) * 8), 8'd8, 32'hAAAA_0008);
    do_read(64'((DEPTH - 2) * 8), 8'd8);
    do_read(64'h0, 8'd6);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] old_data [16];
    for (int i = 0; i < 16; i++) old_data[i] = model[64 + i];
    lcl_istart = 1'b1; lcl_iaddr = 64'h200; lcl_inum = 8'd16;
    lcl_ostart = 1'b1; lcl_oaddr = 64'h200; lcl_onum = 8'd16;
    cyc();
    lcl_istart = 1'b0; lcl_ostart = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b1 || lcl_obusy !== 1'b1) begin
      errors++; $display("FAIL conc_busy: got ibusy=%0b obusy=%0b expected 1/1", lcl_ibusy, lcl_obusy);
    end
    lcl_den = 1'b1; lcl_rden = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lcl_din = pattern(32'hC0C0_0016, i);
      cyc();
      model[64 + i] = pattern(32'hC0C0_0016, i);
      checks++;
      if (lcl_dv !== 1'b1 || lcl_dout !== old_data[i] || lcl_odone !== (i == 15)) begin
        errors++;
        $display("FAIL conc_beat %0d: got dv=%0b dout=%0h odone=%0b expected dv=1 dout=%0h odone=%0b",
                 i, lcl_dv, lcl_dout, lcl_odone, old_data[i], (i == 15));
      end
    end
    lcl_den = 1'b0; lcl_rden = 1'b0;
    lcl_idone = 1'b1;
    cyc();
    lcl_idone = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b0 || lcl_obusy !== 1'b0 || lcl_dv !== 1'b0) begin
      errors++; $display("FAIL conc_end: got ibusy=%0b obusy=%0b dv=%0b expected 0/0/0", lcl_ibusy, lcl_obusy, lcl_dv);
    end
    $display("concurrent burst addr=200 beats=16");
    do_read(64'h200, 8'd16);
  endtask

  task automatic test_early_end();
    lcl_istart = 1'b1; lcl_iaddr = 64'h300; lcl_inum = 8'd8;
    cyc();
    lcl_istart = 1'b0;
    lcl_den = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lcl_din = pattern(32'hEE00_0002, i);
      cyc();
      model[96 + i] = pattern(32'hEE00_0002, i);
    end
    lcl_den = 1'b0;
    lcl_idone = 1'b1;
    cyc();
    lcl_idone = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b0 || lcl_irdy !== 1'b0) begin
      errors++; $display("FAIL early_end: got ibusy=%0b irdy=%0b expected 0/0", lcl_ibusy, lcl_irdy);
    end
    $display("early-ended write addr=300 beats=2 of 8");
    do_read(64'h300, 8'd8);
  endtask

  task automatic test_errchk();
    lcl_istart = 1'b1; lcl_iaddr = 64'h3C0; lcl_inum = 8'd2;
    cyc();
    lcl_istart = 1'b0;
    lcl_den = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lcl_din = pattern(32'hE4E4_0002, i);
      cyc();
      model[120 + i] = pattern(32'hE4E4_0002, i);
    end
    lcl_den = 1'b0;
    // istart while busy: must be ignored
    lcl_istart = 1'b1; lcl_iaddr = 64'h0; lcl_inum = 8'd1;
    cyc();
    lcl_istart = 1'b0;
    cyc();
    // stray den well after irdy fell: must not write
    lcl_den = 1'b1; lcl_din = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc();
    lcl_den = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b1 || lcl_irdy !== 1'b0) begin
      errors++; $display("FAIL err_state: got ibusy=%0b irdy=%0b expected 1/0", lcl_ibusy, lcl_irdy);
    end
    lcl_idone = 1'b1;
    cyc();
    lcl_idone = 1'b0;
    checks++;
    if (lcl_ibusy !== 1'b0 || err_flags !== ERR_EXP) begin
      errors++; $display("FAIL err_flags: got ibusy=%0b err=%0b expected ibusy=0 err=%0b", lcl_ibusy, err_flags, ERR_EXP);
    end
    $display("protocol-violation write addr=3c0 err_flags=%0b", err_flags);
    do_read(64'h3C0, 8'd3);
  endtask

  task automatic test_reset_mid_read();
    lcl_ostart = 1'b1; lcl_oaddr = 64'h100; lcl_onum = 8'd8;
    cyc();
    lcl_ostart = 1'b0;
    lcl_rden = 1'b1;
    cyc();
    cyc();
    checks++;
    if (lcl_dv !== 1'b1 || lcl_dout !== model[33]) begin
      errors++; $display("FAIL pre_reset_beat: got dv=%0b dout=%0h expected dv=1 dout=%0h", lcl_dv, lcl_dout, model[33]);
    end
    rst_n = 1'b0;
    lcl_rden = 1'b0;
    #1;
    checks++;
    if (lcl_dv !== 1'b0 || lcl_odone !== 1'b0 || lcl_obusy !== 1'b0 || lcl_ordy !== 1'b0 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got dv=%0b odone=%0b obusy=%0b ordy=%0b err=%0b expected all 0",
               lcl_dv, lcl_odone, lcl_obusy, lcl_ordy, err_flags);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    $display("reset asserted mid-read");
    do_read(64'h100, 8'd4);
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_early_end();
    test_errchk();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
